median2d_stream: RTL and testbench
==================================

MEDIAN2D_STREAM -- requirements
Module: median2d_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter TAPS, default 7: pixels per input column; odd, 3..9.
REQ-003 SHALL have parameter HIST, default 7: column medians kept in history; odd, 3..9.
REQ-004 SHALL have parameter FILL, default 0: value loaded into empty history slots.
REQ-005 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port refresh  input  1  synchronous pipeline/history flush.
REQ-008 SHALL have port in_valid  input  1  input column present.
REQ-009 SHALL have port in_ready  output  1  block accepts a column this cycle.
REQ-010 SHALL have port in_data  input  TAPS*DATA_WIDTH  column; pixel k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port out_valid  output  1  out_data holds a result.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_data  output  DATA_WIDTH  2-D median result.
REQ-014 SHALL have port out_warm  output  1  history holds HIST real column medians.

Function
REQ-015 SHALL define the pipeline enable en = !out_valid || out_ready, and SHALL drive in_ready = en && !refresh.
REQ-016 SHALL accept a column when in_valid && in_ready.
REQ-017 SHALL compute, in stage 1, the median (rank (TAPS-1)/2, ascending) of the accepted column, and SHALL register it when en is high.
REQ-018 SHALL, in stage 2 and when en is high and stage 1 is valid, shift the stage-1 median into history slot 0 and move slot i to slot i+1, discarding slot HIST-1.
REQ-019 SHALL, in stage 3, register the median (rank (HIST-1)/2) of all HIST history slots into out_data when en is high and stage 2 is valid.
REQ-020 SHALL assert out_valid exactly 3 cycles after acceptance when no stall occurs; each stall cycle (out_valid && !out_ready) SHALL add one cycle.
REQ-021 SHALL hold out_data, out_valid, all stage registers and history stable while stalled, so that no column is lost or duplicated.
REQ-022 SHALL resolve ties in both medians by value only; equal pixels are legal.
REQ-023 SHALL count history insertions in fill_cnt, saturating at HIST; out_warm SHALL be high iff fill_cnt == HIST, aligned with the out_data it describes.
REQ-024 SHALL not retire a result when out_valid is low, regardless of out_ready.

Reset
REQ-025 SHALL, on rst, clear every stage valid bit, set out_valid=0, out_data=0, out_warm=0, fill_cnt=0, and all history slots=FILL.
REQ-026 SHALL, on refresh without rst, apply the same clearing; a column presented in that cycle SHALL NOT be accepted (in_ready=0).
REQ-027 SHALL give rst priority over refresh, and SHALL give refresh priority over stalls and beats; refresh mid-stream SHALL discard all in-flight columns.

Configuration
REQ-028 SHALL, when MEDIAN2D_MINMAX_EN is defined, add outputs out_min and out_max (DATA_WIDTH each) carrying the minimum and maximum of the history window, registered with and aligned to out_data, with reset value 0.
REQ-029 SHALL, when MEDIAN2D_MINMAX_EN is undefined, omit those ports and their logic entirely.

Structure
REQ-030 SHALL place the TAPS/HIST range limits, the fill_cnt width function ($clog2(HIST+1)) and the median-rank constants in shared package median_pkg.
REQ-031 SHALL implement both medians with one sub-module, median_sorter (parameters N, DATA_WIDTH; combinational sorting network; outputs the median and, optionally, the min and max), instantiated twice.

Verification (TAPS=7, HIST=7, DATA_WIDTH=8, FILL=0)
REQ-032 SHALL check: rst held for 2 cycles -> out_valid=0, out_data=0, out_warm=0, in_ready=1.
REQ-033 SHALL check: single column {9,1,8,2,7,3,5} -> 3 cycles later out_valid=1, out_data=0 (history {5,0,0,0,0,0,0}), out_warm=0.
REQ-034 SHALL check: 7 back-to-back columns of all pixels 100 -> outputs 0,0,0,100,100,100,100, with out_warm rising on the 7th output only.
REQ-035 SHALL check: out_ready=0 for 5 cycles while out_valid=1 -> out_data stable, in_ready=0; after release the remaining results appear in order, none missing.
REQ-036 SHALL check: refresh after 4 columns of 100, then one column of 200 -> in-flight results dropped, out_warm=0, next out_data=0.
REQ-037 SHALL check, with MEDIAN2D_MINMAX_EN: column medians 10,20,...,70 -> final out_min=10, out_max=70, out_data=40.

Source files
------------

// File: rtl/median_pkg.sv
// Shared limits and helpers for the 2-D median stream filter.
// Used by median_sorter and median2d_stream.
package median_pkg;

  localparam int TAPS_MIN = 3;
  localparam int TAPS_MAX = 9;
  localparam int HIST_MIN = 3;
  localparam int HIST_MAX = 9;

  function automatic int cnt_w(input int hist);
    return $clog2(hist + 1);
  endfunction

  function automatic int med_rank(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/median_sorter.sv
// Combinational odd-even transposition sort of N values.
// Emits the median, plus {max, min} above it when MINMAX is set.
module median_sorter
  import median_pkg::*;
#(
  parameter int N          = 7,
  parameter int DATA_WIDTH = 8,
  parameter int MINMAX     = 0
) (
  input  logic [N*DATA_WIDTH-1:0] data,
  output logic [(MINMAX != 0 ? 3 : 1)*DATA_WIDTH-1:0] res
);

  localparam int MED = med_rank(N);

  logic [DATA_WIDTH-1:0] s [N];

  always_comb begin : sort
    logic [DATA_WIDTH-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++)
      s[i] = data[i*DATA_WIDTH +: DATA_WIDTH];
    for (int r = 0; r < N; r++) begin
      for (int i = r % 2; i < N - 1; i += 2) begin
        if (s[i] > s[i+1]) begin
          t      = s[i];
          s[i]   = s[i+1];
          s[i+1] = t;
        end
      end
    end
  end

  if (MINMAX != 0) begin : g_mm
    assign res = {s[N-1], s[0], s[MED]};
  end else begin : g_med
    assign res = s[MED];
  end

endmodule

// File: rtl/median2d_stream.sv
// Streaming 2-D median: column median, history shift, window median.
// Define MEDIAN2D_MINMAX_EN to add out_min/out_max of the window.
module median2d_stream
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 7,
  parameter int HIST       = 7,
  parameter logic [DATA_WIDTH-1:0] FILL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       refresh,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAPS*DATA_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
`ifdef MEDIAN2D_MINMAX_EN
  output logic [DATA_WIDTH-1:0]      out_min,
  output logic [DATA_WIDTH-1:0]      out_max,
`endif
  output logic                       out_warm
);

  localparam int CW = cnt_w(HIST);
  localparam int DW = DATA_WIDTH;

  if (TAPS < TAPS_MIN || TAPS > TAPS_MAX || TAPS % 2 == 0)
  begin : g_bad_taps
    $error("median2d_stream: TAPS out of range");
  end
  if (HIST < HIST_MIN || HIST > HIST_MAX || HIST % 2 == 0)
  begin : g_bad_hist
    $error("median2d_stream: HIST out of range");
  end

  logic                 en;
  logic                 accept;
  logic                 s1_valid;
  logic [DW-1:0]        s1_med;
  logic                 s2_valid;
  logic [HIST*DW-1:0]   hist;
  logic [CW-1:0]        fill_cnt;
  logic [DW-1:0]        col_med;
  logic [DW-1:0]        hist_med;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !refresh;
  assign accept   = in_valid && in_ready;

  median_sorter #(
    .N(TAPS), .DATA_WIDTH(DW), .MINMAX(0)
  ) u_col (
    .data(in_data),
    .res (col_med)
  );

`ifdef MEDIAN2D_MINMAX_EN
  logic [3*DW-1:0] hres;

  median_sorter #(
    .N(HIST), .DATA_WIDTH(DW), .MINMAX(1)
  ) u_hist (
    .data(hist),
    .res (hres)
  );

  assign hist_med = hres[DW-1:0];
`else
  median_sorter #(
    .N(HIST), .DATA_WIDTH(DW), .MINMAX(0)
  ) u_hist (
    .data(hist),
    .res (hist_med)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst || refresh) begin
      s1_valid  <= 1'b0;
      s1_med    <= '0;
      s2_valid  <= 1'b0;
      hist      <= {HIST{FILL}};
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_warm  <= 1'b0;
`ifdef MEDIAN2D_MINMAX_EN
      out_min   <= '0;
      out_max   <= '0;
`endif
    end else if (en) begin
      s1_valid <= accept;
      if (accept)
        s1_med <= col_med;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        hist <= {hist[(HIST-1)*DW-1:0], s1_med};
        if (fill_cnt != CW'(HIST))
          fill_cnt <= fill_cnt + 1'b1;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= hist_med;
        // fill_cnt already counts the insertion now sitting in hist
        out_warm <= (fill_cnt == CW'(HIST));
`ifdef MEDIAN2D_MINMAX_EN
        out_min  <= hres[2*DW-1:DW];
        out_max  <= hres[3*DW-1:2*DW];
`endif
      end
    end
  end

endmodule

// File: tb/tb_median2d_stream.sv
// Directed bench for median2d_stream (TAPS=7, HIST=7, 8-bit, FILL=0).
// Define MEDIAN2D_MINMAX_EN to also exercise out_min/out_max.
module tb_median2d_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        refresh;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_warm;
`ifdef MEDIAN2D_MINMAX_EN
  logic [7:0]  out_min;
  logic [7:0]  out_max;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  median2d_stream #(
    .DATA_WIDTH(8), .TAPS(7), .HIST(7), .FILL(8'd0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .refresh  (refresh),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
`ifdef MEDIAN2D_MINMAX_EN
    .out_min  (out_min),
    .out_max  (out_max),
`endif
    .out_warm (out_warm)
  );

  function automatic logic [55:0] col(input logic [7:0] v);
    return {7{v}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    refresh   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%0b exp=0", out_valid);
    end
    total++;
    if (out_data !== 8'd0) begin
      bad++;
      $display("FAIL reset_data got=%0d exp=0", out_data);
    end
    total++;
    if (out_warm !== 1'b0) begin
      bad++;
      $display("FAIL reset_warm got=%0b exp=0", out_warm);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%0b exp=1", in_ready);
    end
  endtask

  task automatic test_idle();
    do_reset();
    out_ready = 1'b0;
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle got v=%0b r=%0b exp v=0 r=1",
               out_valid, in_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    in_data  = {8'd5, 8'd3, 8'd7, 8'd2, 8'd8, 8'd1, 8'd9};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_early got=%0b exp=0", out_valid);
    end
    step();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_valid got=%0b exp=1", out_valid);
    end
    total++;
    if (out_data !== 8'd0 || out_warm !== 1'b0) begin
      bad++;
      $display("FAIL single_data got=%0d/%0b exp=0/0",
               out_data, out_warm);
    end
    total++;
    if (dut.hist[7:0] !== 8'd5) begin
      bad++;
      $display("FAIL single_colmed got=%0d exp=5", dut.hist[7:0]);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_dup got=%0b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [7] = '{0, 0, 0, 100, 100, 100, 100};
    int sent = 0;
    int got  = 0;
    logic acc;
    do_reset();
    for (int c = 0; c < 40 && got < 7; c++) begin
      in_valid = (sent < 7);
      in_data  = col(8'd100);
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        total++;
        if (out_data !== exp[got] || out_warm !== (got == 6)) begin
          bad++;
          $display("FAIL b2b_%0d got=%0d/%0b exp=%0d/%0b",
                   got, out_data, out_warm, exp[got], got == 6);
        end
        got++;
      end
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    total++;
    if (got != 7) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=7", got);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp [7] = '{0, 0, 0, 10, 20, 30, 40};
    int sent = 0;
    int got  = 0;
    int stall_left = 0;
    bit stall_done = 0;
    logic [7:0] held = '0;
    logic acc;
    do_reset();
    for (int c = 0; c < 40 && got < 7; c++) begin
      out_ready = !(stall_left > 0);
      in_valid  = (sent < 7);
      in_data   = col(8'(10 * (sent + 1)));
      #1;
      acc = in_valid && in_ready;
      if (stall_left > 0) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held ||
            in_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold got v=%0b d=%0d r=%0b exp 1/%0d/0",
                   out_valid, out_data, in_ready, held);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== exp[got] || out_warm !== (got == 6)) begin
          bad++;
          $display("FAIL stall_out_%0d got=%0d/%0b exp=%0d/%0b",
                   got, out_data, out_warm, exp[got], got == 6);
        end
        got++;
      end
      step();
      if (acc) sent++;
      if (stall_left > 0) stall_left--;
      if (!stall_done && out_valid && got == 2) begin
        stall_left = 5;
        stall_done = 1;
        held       = out_data;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got != 7 || !stall_done) begin
      bad++;
      $display("FAIL stall_count got=%0d stalled=%0b exp=7/1",
               got, stall_done);
    end
  endtask

  task automatic test_refresh();
    int n = 0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = col(8'd100);
      step();
    end
    refresh  = 1'b1;
    in_valid = 1'b1;
    in_data  = col(8'd100);
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL refresh_ready got=%0b exp=0", in_ready);
    end
    step();
    refresh  = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_warm !== 1'b0) begin
      bad++;
      $display("FAIL refresh_clear got v=%0b w=%0b exp 0/0",
               out_valid, out_warm);
    end
    in_valid = 1'b1;
    in_data  = col(8'd200);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        total++;
        if (out_data !== 8'd0 || out_warm !== 1'b0) begin
          bad++;
          $display("FAIL refresh_out got=%0d/%0b exp=0/0",
                   out_data, out_warm);
        end
        n++;
      end
      step();
    end
    total++;
    if (n != 1) begin
      bad++;
      $display("FAIL refresh_count got=%0d exp=1", n);
    end
  endtask

`ifdef MEDIAN2D_MINMAX_EN
  task automatic test_minmax();
    int got = 0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'b1;
      in_data  = col(8'(10 * (c + 1)));
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10 && got < 7; c++) begin
      if (out_valid) begin
        got++;
        if (got == 7) begin
          total++;
          if (out_min !== 8'd10 || out_max !== 8'd70 ||
              out_data !== 8'd40) begin
            bad++;
            $display("FAIL minmax got=%0d/%0d/%0d exp=10/70/40",
                     out_min, out_max, out_data);
          end
        end
      end
      step();
    end
    total++;
    if (got != 7) begin
      bad++;
      $display("FAIL minmax_count got=%0d exp=7", got);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    refresh   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_stall();
    test_refresh();
`ifdef MEDIAN2D_MINMAX_EN
    test_minmax();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
